// File: rtl/cvxif_copro_responder_if.sv
// Issue/commit/result bundle between a core and an offload coprocessor.
// Signal suffixes follow the responder's view: _i driven by the core, _o by the responder.
interface cvxif_copro_responder_if #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;
    logic [1:0]          issue_rs_valid_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [XLEN-1:0]     result_data_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
               result_id_o, result_data_o, result_rd_o, result_we_o
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
               result_id_o, result_data_o, result_rd_o, result_we_o
    );
endinterface

// File: rtl/cvxif_copro_responder.sv
// In-order ALU coprocessor: result computed at issue, held until commit; result_valid one cycle after commit at head.
// Backpressure: full buffer or missing operands drop issue_ready; a stalled result holds the head in place.
module cvxif_copro_responder #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 4
) (
    input logic                     clk_i,
    input logic                     rst_i,
    cvxif_copro_responder_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {FREE, PENDING, COMMITTED, KILLED} state_e;

    state_e              st_q   [DEPTH];
    state_e              st_d   [DEPTH];
    logic [ID_WIDTH-1:0] id_q   [DEPTH];
    logic [4:0]          rd_q   [DEPTH];
    logic [XLEN-1:0]     data_q [DEPTH];
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [PW:0]         occ_q, occ_d;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       accept;
    logic       alloc;
    logic       pop;
    logic       drop;
    logic       free;
    logic       unused_instr;
    logic [XLEN-1:0] alu;

    assign opcode       = bus.issue_instr_i[6:0];
    assign funct3       = bus.issue_instr_i[14:12];
    assign funct7       = bus.issue_instr_i[31:25];
    assign unused_instr = ^bus.issue_instr_i[24:15];

    always_comb begin
        accept = 1'b0;
        if (opcode == 7'b0001011 && funct7 == 7'd0) begin
            case (funct3)
                3'b000, 3'b001, 3'b100, 3'b110, 3'b111: accept = 1'b1;
                default: accept = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  alu = bus.issue_rs1_i + bus.issue_rs2_i;
            3'b001:  alu = bus.issue_rs1_i - bus.issue_rs2_i;
            3'b100:  alu = bus.issue_rs1_i ^ bus.issue_rs2_i;
            3'b110:  alu = bus.issue_rs1_i | bus.issue_rs2_i;
            default: alu = bus.issue_rs1_i & bus.issue_rs2_i;
        endcase
    end

    assign bus.issue_accept_o    = accept;
    assign bus.issue_writeback_o = accept;
    assign bus.issue_ready_o     = (occ_q < (PW+1)'(DEPTH)) && (bus.issue_rs_valid_i == 2'b11);

    assign alloc = bus.issue_valid_i && bus.issue_ready_o && accept;
    assign pop   = (st_q[head_q] == COMMITTED) && bus.result_ready_i;
    assign drop  = (st_q[head_q] == KILLED);
    assign free  = pop || drop;

    always_comb begin
        st_d   = st_q;
        head_d = head_q;
        tail_d = tail_q;
        if (bus.commit_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (st_q[i] == PENDING && id_q[i] == bus.commit_id_i)
                    st_d[i] = bus.commit_kill_i ? KILLED : COMMITTED;
            end
        end
        if (free) begin
            st_d[head_q] = FREE;
            head_d       = head_q + PW'(1);
        end
        // Tail slot is FREE whenever alloc fires, so it never collides with the loop above or the head free.
        if (alloc) begin
            if (bus.commit_valid_i && bus.commit_id_i == bus.issue_id_i)
                st_d[tail_q] = bus.commit_kill_i ? KILLED : COMMITTED;
            else
                st_d[tail_q] = PENDING;
            tail_d = tail_q + PW'(1);
        end
        occ_d = occ_q + (PW+1)'(alloc) - (PW+1)'(free);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) st_q[i] <= FREE;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            st_q   <= st_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc) begin
            id_q[tail_q]   <= bus.issue_id_i;
            rd_q[tail_q]   <= bus.issue_instr_i[11:7];
            data_q[tail_q] <= alu;
        end
    end

    assign bus.result_valid_o = (st_q[head_q] == COMMITTED);
    assign bus.result_id_o    = id_q[head_q];
    assign bus.result_data_o  = data_q[head_q];
    assign bus.result_rd_o    = rd_q[head_q];
    assign bus.result_we_o    = (st_q[head_q] == COMMITTED);
endmodule
